wash_timer_controller: RTL and testbench

//  Timing/supervision controller for automatic_washing_machine. Generates the cycle_timeout and spin_timeout

---
 rtl/wash_timer_controller_pkg.sv | 56 +++++
 rtl/wash_timer_controller_if.sv | 46 ++++
 rtl/wash_timer_controller_watchdog.sv | 41 ++++
 rtl/wash_timer_controller.sv | 192 +++++++++++++++++++
 tb/tb_wash_timer_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wash_timer_controller_pkg.sv
// -----------------------------------------------------------------------------
// wash_ctrl_pkg
// Shared types and helpers for the wash timer / supervision controller.
//   - wash_state_t : 3-bit FSM state encoding
//   - wash_prog_t  : wash program select codes
//   - fault_code_t : sticky fault cause codes
//   - wash_duration: maps a program code to its wash duration
// Optional feature macro used elsewhere in this slice: WASH_PAUSE_EN.
// -----------------------------------------------------------------------------
package wash_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WASH      = 3'd1,
        ST_WASH_DONE = 3'd2,
        ST_SPIN      = 3'd3,
        ST_SPIN_DONE = 3'd4,
        ST_FAULT     = 3'd5
    } wash_state_t;

    typedef enum logic [1:0] {
        PROG_QUICK  = 2'b00,
        PROG_NORMAL = 2'b01,
        PROG_HEAVY  = 2'b10,
        PROG_RSVD   = 2'b11
    } wash_prog_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_FILL     = 2'b01,
        FC_DRAIN    = 2'b10,
        FC_RUN_BOTH = 2'b11
    } fault_code_t;

    // Watchdog slots; fill sits at the lower index and wins ties.
    localparam int NUM_WATCHDOGS = 2;
    localparam int WD_FILL       = 0;
    localparam int WD_DRAIN      = 1;

    // Reserved program code falls back to the normal duration.
    function automatic int wash_duration(
        input logic [1:0] prog,
        input int         t_quick,
        input int         t_normal,
        input int         t_heavy
    );
        int d;
        case (prog)
            PROG_QUICK: d = t_quick;
            PROG_HEAVY: d = t_heavy;
            default:    d = t_normal;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wash_timer_controller_if.sv
// -----------------------------------------------------------------------------
// wash_timer_if
// Signal bundle between the washer FSM (master) and the timer/supervision
// controller (slave).
//   master drives : prog, wash_run, spin_run, fill_value_on, drain_value_on,
//                   fault_clr, pause (only when WASH_PAUSE_EN is defined)
//   slave drives  : cycle_timeout, spin_timeout, time_left, fault, fault_code
// Macro: WASH_PAUSE_EN adds the pause signal.
// -----------------------------------------------------------------------------
interface wash_timer_if #(
    parameter int CNT_W = 16
) ();
    import wash_ctrl_pkg::*;

    logic [1:0]       prog;
    logic             wash_run;
    logic             spin_run;
    logic             fill_value_on;
    logic             drain_value_on;
    logic             fault_clr;
`ifdef WASH_PAUSE_EN
    logic             pause;
`endif
    logic             cycle_timeout;
    logic             spin_timeout;
    logic [CNT_W-1:0] time_left;
    logic             fault;
    logic [1:0]       fault_code;

    modport master (
`ifdef WASH_PAUSE_EN
        output pause,
`endif
        output prog, wash_run, spin_run, fill_value_on, drain_value_on, fault_clr,
        input  cycle_timeout, spin_timeout, time_left, fault, fault_code
    );

    modport slave (
`ifdef WASH_PAUSE_EN
        input  pause,
`endif
        input  prog, wash_run, spin_run, fill_value_on, drain_value_on, fault_clr,
        output cycle_timeout, spin_timeout, time_left, fault, fault_code
    );

endinterface

// File: rtl/wash_timer_controller_watchdog.sv
// -----------------------------------------------------------------------------
// wash_watchdog
// Counts consecutive cycles with en=1 and asserts trip on the edge that would
// record the LIMIT-th consecutive high sample. en=0 clears the run.
// Ports:
//   clk   in  clock
//   reset in  synchronous active-high reset
//   en    in  monitored level (already gated off by the parent when halted)
//   clr   in  synchronous clear
//   trip  out combinational: this edge completes LIMIT consecutive samples
// -----------------------------------------------------------------------------
module wash_watchdog #(
    parameter int CNT_W = 16,
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic trip
);
    import wash_ctrl_pkg::*;

    localparam int               LIM_EFF = (LIMIT < 1) ? 1 : LIMIT;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(LIM_EFF - 1);

    logic [CNT_W-1:0] r_cnt;

    assign trip = en && !clr && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (!en) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wash_timer_controller.sv
// -----------------------------------------------------------------------------
// wash_timer_controller
// Generates cycle_timeout / spin_timeout for the washer FSM from programmable
// durations, reports the remaining time of the active phase, and supervises
// the fill/drain valves plus wash/spin run overlap with a sticky fault.
// Ports:
//   clk    in   single rising-edge clock
//   reset  in   synchronous active-high reset
//   bus    slave modport of wash_timer_if (run levels, valves, prog, fault_clr,
//          optional pause in; timeouts, time_left, fault, fault_code out)
// Macro: WASH_PAUSE_EN enables the pause input, which freezes the phase
// counter while the watchdogs keep running.
// -----------------------------------------------------------------------------
module wash_timer_controller
    import wash_ctrl_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int T_WASH_QUICK  = 100,
    parameter int T_WASH_NORMAL = 200,
    parameter int T_WASH_HEAVY  = 400,
    parameter int T_SPIN        = 50,
    parameter int T_FILL_MAX    = 1000,
    parameter int T_DRAIN_MAX   = 1000
) (
    input  logic           clk,
    input  logic           reset,
    wash_timer_if.slave    bus
);

    // A zero duration would never match cnt==dur-1, so it is promoted to 1.
    localparam logic [CNT_W-1:0] DUR_SPIN =
        (CNT_W'(T_SPIN) == '0) ? CNT_W'(1) : CNT_W'(T_SPIN);

    wash_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_dur;
    logic [CNT_W-1:0] r_time_left;
    logic             r_cycle_timeout;
    logic             r_spin_timeout;
    logic             r_fault;
    logic [1:0]       r_fault_code;

    logic [CNT_W-1:0]         w_dur_sel;
    logic                     w_pause;
    logic                     w_phase_run;
    logic                     w_phase_last;
    logic                     w_wd_active;
    logic                     w_wd_clr;
    logic [NUM_WATCHDOGS-1:0] w_wd_level;
    logic [NUM_WATCHDOGS-1:0] w_wd_trip;
    fault_code_t              w_trip_code;

`ifdef WASH_PAUSE_EN
    assign w_pause = bus.pause;
`else
    assign w_pause = 1'b0;
`endif

    always_comb begin
        w_dur_sel = CNT_W'(wash_duration(bus.prog, T_WASH_QUICK, T_WASH_NORMAL, T_WASH_HEAVY));
        if (w_dur_sel == '0) begin
            w_dur_sel = CNT_W'(1);
        end
    end

    // The run level that keeps the current phase alive.
    assign w_phase_run  = (r_state == ST_WASH || r_state == ST_WASH_DONE) ? bus.wash_run
                                                                          : bus.spin_run;
    assign w_phase_last = (r_cnt == r_dur - CNT_W'(1));

    // Watchdogs are halted in FAULT and cleared when the fault is acknowledged.
    assign w_wd_active          = (r_state != ST_FAULT);
    assign w_wd_clr             = (r_state == ST_FAULT) && bus.fault_clr;
    assign w_wd_level[WD_FILL]  = bus.fill_value_on;
    assign w_wd_level[WD_DRAIN] = bus.drain_value_on;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WATCHDOGS; gi++) begin : g_wd
            wash_watchdog #(
                .CNT_W (CNT_W),
                .LIMIT ((gi == WD_FILL) ? T_FILL_MAX : T_DRAIN_MAX)
            ) u_wd (
                .clk   (clk),
                .reset (reset),
                .en    (w_wd_level[gi] && w_wd_active),
                .clr   (w_wd_clr),
                .trip  (w_wd_trip[gi])
            );
        end
    endgenerate

    // Fault cause for this edge; fill beats drain beats run overlap.
    always_comb begin
        w_trip_code = FC_NONE;
        if (w_wd_trip[WD_FILL]) begin
            w_trip_code = FC_FILL;
        end else if (w_wd_trip[WD_DRAIN]) begin
            w_trip_code = FC_DRAIN;
        end else if (r_state == ST_IDLE && bus.wash_run && bus.spin_run) begin
            w_trip_code = FC_RUN_BOTH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_dur           <= '0;
            r_time_left     <= '0;
            r_cycle_timeout <= 1'b0;
            r_spin_timeout  <= 1'b0;
            r_fault         <= 1'b0;
            r_fault_code    <= FC_NONE;
        end else if (r_state == ST_FAULT) begin
            // Counters stay frozen until the fault is acknowledged.
            if (bus.fault_clr) begin
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
                r_fault      <= 1'b0;
                r_fault_code <= FC_NONE;
            end
        end else if (w_trip_code != FC_NONE) begin
            r_state         <= ST_FAULT;
            r_fault         <= 1'b1;
            r_fault_code    <= w_trip_code;
            r_cycle_timeout <= 1'b0;
            r_spin_timeout  <= 1'b0;
            r_time_left     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.wash_run) begin
                        r_state     <= ST_WASH;
                        r_dur       <= w_dur_sel;
                        r_cnt       <= '0;
                        r_time_left <= w_dur_sel;
                    end else if (bus.spin_run) begin
                        r_state     <= ST_SPIN;
                        r_dur       <= DUR_SPIN;
                        r_cnt       <= '0;
                        r_time_left <= DUR_SPIN;
                    end
                end

                ST_WASH, ST_SPIN: begin
                    if (!w_phase_run) begin
                        // Aborted before expiry: no timeout pulse.
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_time_left <= '0;
                    end else if (w_pause) begin
                        r_cnt <= r_cnt;
                    end else if (w_phase_last) begin
                        r_cnt       <= '0;
                        r_time_left <= '0;
                        if (r_state == ST_WASH) begin
                            r_state         <= ST_WASH_DONE;
                            r_cycle_timeout <= 1'b1;
                        end else begin
                            r_state        <= ST_SPIN_DONE;
                            r_spin_timeout <= 1'b1;
                        end
                    end else begin
                        r_cnt       <= r_cnt + CNT_W'(1);
                        r_time_left <= r_dur - r_cnt - CNT_W'(1);
                    end
                end

                ST_WASH_DONE, ST_SPIN_DONE: begin
                    // Timeout is held until the washer acknowledges by dropping run.
                    if (!w_phase_run) begin
                        r_state         <= ST_IDLE;
                        r_cycle_timeout <= 1'b0;
                        r_spin_timeout  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cycle_timeout = r_cycle_timeout;
    assign bus.spin_timeout  = r_spin_timeout;
    assign bus.time_left     = r_time_left;
    assign bus.fault         = r_fault;
    assign bus.fault_code    = r_fault_code;

endmodule

// File: tb/tb_wash_timer_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for wash_timer_controller: a reference model pushes the
// expected outputs after every clock edge, a monitor pops and compares them.
module tb_wash_timer_controller;
    import wash_ctrl_pkg::*;

    localparam int CNT_W = 16;
    localparam int T_Q   = 100;
    localparam int T_N   = 200;
    localparam int T_H   = 400;
    localparam int T_S   = 50;
    localparam int T_F   = 1000;
    localparam int T_D   = 1000;
`ifdef WASH_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic tb_pause;

    always #5 clk = ~clk;

    wash_timer_if #(.CNT_W(CNT_W)) bus ();

`ifdef WASH_PAUSE_EN
    assign bus.pause = tb_pause;
`endif

    wash_timer_controller #(
        .CNT_W(CNT_W), .T_WASH_QUICK(T_Q), .T_WASH_NORMAL(T_N), .T_WASH_HEAVY(T_H),
        .T_SPIN(T_S), .T_FILL_MAX(T_F), .T_DRAIN_MAX(T_D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic             ct;
        logic             st;
        logic [CNT_W-1:0] tl;
        logic             flt;
        logic [1:0]       code;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_a;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    // Reference model: phase 0=none, 1=wash, 2=spin; elapsed counts run edges
    // after the entry edge; the phase has expired once elapsed reaches dur.
    int         m_phase, m_elapsed, m_dur, m_fill, m_drain;
    bit         m_fault;
    logic [1:0] m_code;

    function automatic int prog_dur(input logic [1:0] p);
        if (p == 2'b00) return T_Q;
        if (p == 2'b10) return T_H;
        return T_N;
    endfunction

    task automatic model_step();
        exp_t e;
        bit   run;
        bit   pz;
        pz = PAUSE_EN && tb_pause;
        if (reset) begin
            m_phase = 0; m_elapsed = 0; m_dur = 0; m_fill = 0; m_drain = 0;
            m_fault = 0; m_code = 2'b00;
        end else if (m_fault) begin
            if (bus.fault_clr) begin
                m_fault = 0; m_code = 2'b00; m_fill = 0; m_drain = 0; m_phase = 0;
            end
        end else begin
            m_fill  = bus.fill_value_on  ? m_fill + 1  : 0;
            m_drain = bus.drain_value_on ? m_drain + 1 : 0;
            if (m_fill >= T_F) begin
                m_fault = 1; m_code = 2'b01;
            end else if (m_drain >= T_D) begin
                m_fault = 1; m_code = 2'b10;
            end else if (m_phase == 0) begin
                if (bus.wash_run && bus.spin_run) begin
                    m_fault = 1; m_code = 2'b11;
                end else if (bus.wash_run) begin
                    m_phase = 1; m_dur = prog_dur(bus.prog); m_elapsed = 0;
                end else if (bus.spin_run) begin
                    m_phase = 2; m_dur = T_S; m_elapsed = 0;
                end
            end else begin
                run = (m_phase == 1) ? bus.wash_run : bus.spin_run;
                if (!run) m_phase = 0;
                else if (m_elapsed < m_dur && !pz) m_elapsed++;
            end
        end
        e.ct   = !m_fault && m_phase == 1 && m_elapsed == m_dur;
        e.st   = !m_fault && m_phase == 2 && m_elapsed == m_dur;
        e.tl   = (!m_fault && m_phase != 0 && m_elapsed < m_dur) ? CNT_W'(m_dur - m_elapsed) : '0;
        e.flt  = m_fault;
        e.code = m_fault ? m_code : 2'b00;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: one comparison per presented output sample.
    initial begin
        forever begin
            @(negedge clk);
            cyc_no++;
            if (exp_q.size() != 0) begin
                mon_e      = exp_q.pop_front();
                mon_a.ct   = bus.cycle_timeout;
                mon_a.st   = bus.spin_timeout;
                mon_a.tl   = bus.time_left;
                mon_a.flt  = bus.fault;
                mon_a.code = bus.fault_code;
                n_checks++;
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL outputs@cyc%0d: got ct=%0b st=%0b tl=%0d f=%0b code=%0d, expected ct=%0b st=%0b tl=%0d f=%0b code=%0d",
                             cyc_no, mon_a.ct, mon_a.st, mon_a.tl, mon_a.flt, mon_a.code,
                             mon_e.ct, mon_e.st, mon_e.tl, mon_e.flt, mon_e.code);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle_inputs();
        bus.wash_run = 1'b0; bus.spin_run = 1'b0; bus.fill_value_on = 1'b0;
        bus.drain_value_on = 1'b0; bus.fault_clr = 1'b0; tb_pause = 1'b0;
    endtask

    // Leave the DUT in IDLE with the model agreeing.
    task automatic settle();
        idle_inputs();
        step(1);
        if (m_fault) begin
            bus.fault_clr = 1'b1;
            step(1);
            bus.fault_clr = 1'b0;
        end
        step(1);
    endtask

    task automatic run_phase(input bit is_wash, input int hold, input int pause_pct, input int valve_pct);
        for (int k = 0; k < hold; k++) begin
            bus.wash_run       = is_wash;
            bus.spin_run       = !is_wash;
            bus.prog           = 2'($urandom_range(0, 3));
            tb_pause           = ($urandom_range(0, 99) < pause_pct);
            bus.fill_value_on  = ($urandom_range(0, 99) < valve_pct);
            bus.drain_value_on = ($urandom_range(0, 99) < valve_pct);
            step(1);
        end
        settle();
    endtask

    initial begin
        int kind, d, hold, t0;
        logic [1:0] p;
        reset = 1'b1;
        bus.prog = 2'b00;
        idle_inputs();
        step(3);
        reset = 1'b0;
        chk("reset_time_left", int'(bus.time_left), 0);
        chk("reset_fault", int'(bus.fault), 0);
        step(1);

        // 1 + 3: quick wash, time_left midway, timeout hold, drop on run=0.
        bus.prog = 2'b00; bus.wash_run = 1'b1;
        step(51);
        chk("t1_time_left_mid", int'(bus.time_left), 50);
        step(49);
        chk("t1_no_early_timeout", int'(bus.cycle_timeout), 0);
        step(1);
        chk("t1_cycle_timeout", int'(bus.cycle_timeout), 1);
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("t3_timeout_held", int'(bus.cycle_timeout), 1);
        end
        bus.wash_run = 1'b0;
        step(1);
        chk("t3_timeout_drop", int'(bus.cycle_timeout), 0);
        $display("txn directed-1/3: quick wash timeout and hold");

        // 2: spin abort then restart from zero.
        bus.spin_run = 1'b1;
        step(20);
        chk("t2_spin_tl", int'(bus.time_left), 31);
        bus.spin_run = 1'b0;
        step(1);
        chk("t2_abort_tl", int'(bus.time_left), 0);
        chk("t2_abort_st", int'(bus.spin_timeout), 0);
        bus.spin_run = 1'b1;
        step(1);
        chk("t2_rerun_tl", int'(bus.time_left), 50);
        step(50);
        chk("t2_spin_timeout", int'(bus.spin_timeout), 1);
        settle();
        $display("txn directed-2: spin abort and rerun");

        // 4: fill stuck during a wash.
        bus.prog = 2'b00; bus.wash_run = 1'b1; bus.fill_value_on = 1'b1;
        step(999);
        chk("t4_no_fault_yet", int'(bus.fault), 0);
        step(1);
        chk("t4_fault", int'(bus.fault), 1);
        chk("t4_code_fill", int'(bus.fault_code), 1);
        chk("t4_ct_low", int'(bus.cycle_timeout), 0);
        bus.wash_run = 1'b0; bus.fill_value_on = 1'b0; bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        chk("t4_fault_cleared", int'(bus.fault), 0);
        settle();
        $display("txn directed-4: fill stuck fault and clear");

        // 5: run overlap fault, then reset mid-wash.
        bus.wash_run = 1'b1; bus.spin_run = 1'b1;
        step(1);
        chk("t5_fault", int'(bus.fault), 1);
        chk("t5_code_both", int'(bus.fault_code), 3);
        settle();
        bus.prog = 2'b00; bus.wash_run = 1'b1;
        step(38);
        chk("t5_tl_cnt37", int'(bus.time_left), 63);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t5_reset_tl", int'(bus.time_left), 0);
        settle();
        $display("txn directed-5: overlap fault and mid-wash reset");

`ifdef WASH_PAUSE_EN
        // 6: normal wash with a 30-cycle pause.
        bus.prog = 2'b01; bus.wash_run = 1'b1;
        step(100);
        tb_pause = 1'b1;
        step(30);
        tb_pause = 1'b0;
        chk("t6_tl_frozen", int'(bus.time_left), 101);
        step(100);
        chk("t6_no_timeout_230", int'(bus.cycle_timeout), 0);
        step(1);
        chk("t6_timeout_231", int'(bus.cycle_timeout), 1);
        settle();
        $display("txn directed-6: paused wash");
`endif

        // Randomized episodes against the model.
        for (int ep = 0; ep < 40; ep++) begin
            kind = $urandom_range(0, 9);
            t0 = cyc_no;
            case (kind)
                0, 1, 2, 3: begin
                    p = 2'($urandom_range(0, 3));
                    bus.prog = p;
                    d = prog_dur(p);
                    hold = $urandom_range(0, 1) ? $urandom_range(1, d) : d + $urandom_range(1, 8);
                    run_phase(1'b1, hold, $urandom_range(0, 1) * 20, 10);
                end
                4, 5: begin
                    hold = $urandom_range(0, 1) ? $urandom_range(1, T_S) : T_S + $urandom_range(1, 8);
                    run_phase(1'b0, hold, $urandom_range(0, 1) * 20, 10);
                end
                6: begin
                    bus.wash_run = 1'b1; bus.spin_run = 1'b1;
                    step($urandom_range(1, 3));
                    settle();
                end
                7: begin
                    d = $urandom_range(0, 2);
                    bus.fill_value_on  = (d != 1);
                    bus.drain_value_on = (d != 0);
                    bus.wash_run       = 1'($urandom_range(0, 1));
                    step(T_F + $urandom_range(0, 4));
                    bus.fault_clr = 1'b1;
                    step(1);
                    bus.fault_clr = 1'b0;
                    step($urandom_range(1, 5));
                    settle();
                end
                8: begin
                    bus.prog = 2'($urandom_range(0, 3));
                    bus.wash_run = 1'b1;
                    step($urandom_range(1, 90));
                    reset = 1'b1;
                    step(1);
                    reset = 1'b0;
                    settle();
                end
                default: begin
                    for (int k = 0; k < 40; k++) begin
                        bus.prog           = 2'($urandom_range(0, 3));
                        bus.wash_run       = ($urandom_range(0, 3) != 0);
                        bus.spin_run       = ($urandom_range(0, 7) == 0);
                        bus.fill_value_on  = 1'($urandom_range(0, 1));
                        bus.drain_value_on = 1'($urandom_range(0, 1));
                        bus.fault_clr      = ($urandom_range(0, 7) == 0);
                        tb_pause           = ($urandom_range(0, 3) == 0);
                        step(1);
                    end
                    settle();
                end
            endcase
            $display("txn random %0d: kind=%0d cycles=%0d", ep, kind, cyc_no - t0);
        end

        step(1);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
